// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse packet decoder.
// State encodings, byte0 field positions and defaults.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    UPDATE
  } state_t;

  localparam int BTN_LO    = 0;
  localparam int BTN_HI    = 2;
  localparam int SYNC_BIT  = 3;
  localparam int XSIGN_BIT = 4;
  localparam int YSIGN_BIT = 5;
  localparam int XOVF_BIT  = 6;
  localparam int YOVF_BIT  = 7;

  localparam logic [7:0] ACK_BYTE = 8'hFA;

  localparam int X_MAX_DEF   = 639;
  localparam int Y_MAX_DEF   = 479;
  localparam int TIMEOUT_DEF = 150000;

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: add or subtract a 9-bit signed delta,
// skip on overflow, clamp the result to [0, MAX].
module mouse_axis_accum #(
  parameter int MAX = 639,
  parameter bit SUB = 1'b0
) (
  input  logic [9:0] cur,
  input  logic [8:0] delta,
  input  logic       ovf,
  output logic [9:0] nxt
);

  localparam logic signed [10:0] LIM = 11'(MAX);

  logic signed [10:0] d;
  logic signed [10:0] base;
  logic signed [10:0] sum;

  always_comb begin
    d    = {{2{delta[8]}}, delta};
    base = {1'b0, cur};
    sum  = SUB ? base - d : base + d;
    nxt  = cur;
    if (!ovf) begin
      if (sum[10])
        nxt = '0;
      else if (sum > LIM)
        nxt = LIM[9:0];
      else
        nxt = sum[9:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse 3-byte packet decoder with ack skip,
// inter-byte timeout and clamped cursor accumulation.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int X_MAX          = X_MAX_DEF,
  parameter int Y_MAX          = Y_MAX_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic       packet_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       sync_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          ack_pending;
  logic [CW-1:0] idle_cnt;
  logic [2:0]    b0_btn;
  logic          b0_xs;
  logic          b0_ys;
  logic          b0_xo;
  logic          b0_yo;
  logic [7:0]    byte1;
  logic [9:0]    nx_x;
  logic [9:0]    nx_y;
  logic          mid;
  logic          tmo;

  assign mid = (state == WAIT_B1) || (state == WAIT_B2);
  assign tmo = mid && (idle_cnt == CW'(TIMEOUT_CYCLES));

  mouse_axis_accum #(.MAX(X_MAX), .SUB(1'b0)) u_ax (
    .cur   (cursor_x),
    .delta (dx),
    .ovf   (x_ovf),
    .nxt   (nx_x)
  );

  // Screen Y grows downward while mouse dy is up-positive.
  mouse_axis_accum #(.MAX(Y_MAX), .SUB(1'b1)) u_ay (
    .cur   (cursor_y),
    .delta (dy),
    .ovf   (y_ovf),
    .nxt   (nx_y)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= WAIT_B0;
      ack_pending  <= 1'b1;
      idle_cnt     <= '0;
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
      buttons      <= '0;
      dx           <= '0;
      dy           <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
      cursor_x     <= 10'(X_MAX / 2);
      cursor_y     <= 10'(Y_MAX / 2);
      b0_btn       <= '0;
      b0_xs        <= 1'b0;
      b0_ys        <= 1'b0;
      b0_xo        <= 1'b0;
      b0_yo        <= 1'b0;
      byte1        <= '0;
    end else begin
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
      if (rx_data_en || !mid || tmo)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      if (state == UPDATE) begin
        cursor_x <= nx_x;
        cursor_y <= nx_y;
      end
      if (rx_data_en) begin
        ack_pending <= 1'b0;
        unique case (state)
          WAIT_B1: begin
            byte1 <= rx_data;
            state <= WAIT_B2;
          end
          WAIT_B2: begin
            buttons      <= b0_btn;
            dx           <= {b0_xs, byte1};
            dy           <= {b0_ys, rx_data};
            x_ovf        <= b0_xo;
            y_ovf        <= b0_yo;
            packet_valid <= 1'b1;
            state        <= UPDATE;
          end
          default: begin
            if (ack_pending && rx_data == ACK_BYTE) begin
              state <= WAIT_B0;
            end else if (rx_data[SYNC_BIT]) begin
              b0_btn <= rx_data[BTN_HI:BTN_LO];
              b0_xs  <= rx_data[XSIGN_BIT];
              b0_ys  <= rx_data[YSIGN_BIT];
              b0_xo  <= rx_data[XOVF_BIT];
              b0_yo  <= rx_data[YOVF_BIT];
              state  <= WAIT_B1;
            end else begin
              sync_error <= 1'b1;
              state      <= WAIT_B0;
            end
          end
        endcase
      end else if (tmo) begin
        sync_error <= 1'b1;
        state      <= WAIT_B0;
      end else if (state == UPDATE) begin
        state <= WAIT_B0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Bench for mouse_packet_decoder: packet-level model,
// per-cycle compare, directed literals and random traffic.
module tb_mouse_packet_decoder;

  localparam int XM = 639;
  localparam int YM = 479;
  localparam int TO = 40;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_en;
  logic       packet_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic       sync_error;

  int n_chk  = 0;
  int n_fail = 0;
  int npv    = 0;
  int nse    = 0;

  mouse_packet_decoder #(
    .X_MAX          (XM),
    .Y_MAX          (YM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_data_en   (rx_data_en),
    .packet_valid (packet_valid),
    .buttons      (buttons),
    .dx           (dx),
    .dy           (dy),
    .x_ovf        (x_ovf),
    .y_ovf        (y_ovf),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .sync_error   (sync_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of pending packet bytes,
  // cycles since last byte, and plain integer cursors.
  logic [7:0] q[$];
  bit         m_ack;
  bit         m_upd;
  int         m_idle;
  logic       m_pv;
  logic       m_se;
  logic [2:0] m_btn;
  logic [8:0] m_dx;
  logic [8:0] m_dy;
  logic       m_xo;
  logic       m_yo;
  int         m_cx;
  int         m_cy;

  function automatic int sx9(logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ack  = 1'b1;
      m_upd  = 1'b0;
      m_idle = 0;
      m_pv   = 1'b0;
      m_se   = 1'b0;
      m_btn  = '0;
      m_dx   = '0;
      m_dy   = '0;
      m_xo   = 1'b0;
      m_yo   = 1'b0;
      m_cx   = XM / 2;
      m_cy   = YM / 2;
    end else begin
      m_pv = 1'b0;
      m_se = 1'b0;
      if (m_upd) begin
        if (!m_xo) m_cx = clampi(m_cx + sx9(m_dx), XM);
        if (!m_yo) m_cy = clampi(m_cy - sx9(m_dy), YM);
        m_upd = 1'b0;
      end
      if (rx_data_en) begin
        m_idle = 0;
        if (q.size() == 0) begin
          if (m_ack && rx_data == 8'hFA) begin
          end else if (rx_data[3]) begin
            q.push_back(rx_data);
          end else begin
            m_se = 1'b1;
          end
        end else if (q.size() == 1) begin
          q.push_back(rx_data);
        end else begin
          m_btn = q[0][2:0];
          m_dx  = {q[0][4], q[1]};
          m_dy  = {q[0][5], rx_data};
          m_xo  = q[0][6];
          m_yo  = q[0][7];
          m_pv  = 1'b1;
          m_upd = 1'b1;
          q.delete();
        end
        m_ack = 1'b0;
      end else if (q.size() > 0) begin
        m_idle++;
        if (m_idle > TO) begin
          m_se   = 1'b1;
          m_idle = 0;
          q.delete();
        end
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (reset === 1'b0) begin
      if (packet_valid) npv++;
      if (sync_error) nse++;
      chk("packet_valid", packet_valid, m_pv);
      chk("sync_error", sync_error, m_se);
      chk("buttons", buttons, m_btn);
      chk("dx", dx, m_dx);
      chk("dy", dy, m_dy);
      chk("x_ovf", x_ovf, m_xo);
      chk("y_ovf", y_ovf, m_yo);
      chk("cursor_x", cursor_x, m_cx);
      chk("cursor_y", cursor_y, m_cy);
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic send(logic [7:0] d, int gap);
    rx_data    = d;
    rx_data_en = 1'b1;
    tick();
    rx_data_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send3(logic [7:0] a, logic [7:0] b,
                       logic [7:0] c);
    send(a, 0);
    send(b, 0);
    send(c, 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    npv = 0;
    nse = 0;
  endtask

  initial begin
    int r;
    int g;
    logic [7:0] d;
    reset      = 1'b0;
    rx_data    = '0;
    rx_data_en = 1'b0;
    #1;
    do_reset();

    chk("rst_cursor_x", cursor_x, 319);
    chk("rst_cursor_y", cursor_y, 239);
    chk("rst_dx", dx, 0);
    chk("rst_buttons", buttons, 0);

    send(8'hFA, 0);
    send3(8'h08, 8'h05, 8'h03);
    chk("ack_pv_count", npv, 1);
    chk("ack_se_count", nse, 0);
    chk("ack_dx", dx, 5);
    chk("ack_dy", dy, 3);
    chk("ack_cursor_x", cursor_x, 324);
    chk("ack_cursor_y", cursor_y, 236);
    chk("model_cursor_x", m_cx, 324);

    do_reset();
    send3(8'h38, 8'hFB, 8'hFE);
    chk("neg_dx", dx, 9'h1FB);
    chk("neg_dy", dy, 9'h1FE);
    chk("neg_cursor_x", cursor_x, 314);
    chk("neg_cursor_y", cursor_y, 241);

    do_reset();
    send3(8'h08, 8'h7F, 8'h00);
    chk("clamp_x1", cursor_x, 446);
    send3(8'h08, 8'h7F, 8'h00);
    chk("clamp_x2", cursor_x, 573);
    send3(8'h08, 8'h7F, 8'h00);
    chk("clamp_x3", cursor_x, 639);

    do_reset();
    send(8'h00, 2);
    chk("sync_se_count", nse, 1);
    chk("sync_pv_count", npv, 0);
    send3(8'h09, 8'h00, 8'h00);
    chk("sync_buttons", buttons, 3'b001);

    do_reset();
    send(8'h08, 0);
    send(8'h10, TO + 4);
    chk("tmo_se_count", nse, 1);
    chk("tmo_pv_count", npv, 0);
    send3(8'h0A, 8'h01, 8'h01);
    chk("tmo_buttons", buttons, 3'b010);
    chk("tmo_dx", dx, 1);
    chk("tmo_dy", dy, 1);

    do_reset();
    send3(8'h48, 8'hFF, 8'h00);
    chk("ovf_flag", x_ovf, 1);
    chk("ovf_dx", dx, 255);
    chk("ovf_cursor_x", cursor_x, 319);

    do_reset();
    send3(8'h08, 8'h05, 8'h03);
    send(8'h08, 0);
    send(8'h01, 0);
    npv = 0;
    nse = 0;
    do_reset();
    repeat (3) tick();
    chk("midrst_pv", npv, 0);
    chk("midrst_se", nse, 0);
    chk("midrst_cursor_x", cursor_x, 319);
    chk("midrst_dx", dx, 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      d = 8'($urandom);
      if (r < 5) begin
        do_reset();
        if ($urandom_range(0, 1) == 1) send(8'hFA, 0);
      end else begin
        if (r < 700) d[3] = 1'b1;
        r = $urandom_range(0, 99);
        if (r < 70)
          g = $urandom_range(0, 2);
        else if (r < 92)
          g = $urandom_range(3, 8);
        else
          g = $urandom_range(TO - 2, TO + 3);
        send(d, g);
      end
    end
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_packet_decoder.md
MOUSE_PACKET_DECODER -- requirements
Module: mouse_packet_decoder

Interface
REQ-001 The clock SHALL be CLOCK_50, the single clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter X_MAX, default 639: maximum cursor X, inclusive.
REQ-003 Parameter Y_MAX, default 479: maximum cursor Y, inclusive.
REQ-004 Parameter TIMEOUT_CYCLES, default 150000 (3 ms at 50 MHz): maximum idle gap between bytes inside one packet.
REQ-005 Ports SHALL be:
- CLOCK_50  in  1  clock
- reset  in  1  async active-high reset
- rx_data  in  8  byte from the PS/2 receiver
- rx_data_en  in  1  one-cycle strobe; rx_data valid in that cycle
- packet_valid  out  1  one-cycle pulse; a decoded packet is present
- buttons  out  3  [0]=left, [1]=right, [2]=middle
- dx  out  9  signed X delta {byte0[4], byte1}
- dy  out  9  signed Y delta {byte0[5], byte2}
- x_ovf  out  1  byte0[6]
- y_ovf  out  1  byte0[7]
- cursor_x  out  10  accumulated X position
- cursor_y  out  10  accumulated Y position, screen-down positive
- sync_error  out  1  one-cycle pulse on a discarded byte or packet

Function
REQ-006 FSM states SHALL be WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE.
REQ-007 In WAIT_B0, a strobed byte SHALL be handled as follows:
- byte[3]==1: latch it as byte0 and go to WAIT_B1.
- byte[3]==0: discard it, pulse sync_error and stay in WAIT_B0.
REQ-008 While ack_pending is set, the first strobed byte 0xFA SHALL be discarded silently and SHALL clear ack_pending. Any other first byte SHALL clear ack_pending and be processed normally.
REQ-009 In WAIT_B1, a strobe SHALL latch byte1 and go to WAIT_B2.
REQ-010 In WAIT_B2, a strobe SHALL latch byte2 and go to UPDATE.
REQ-011 On the edge that accepts byte2, the block SHALL register buttons, dx, dy, x_ovf and y_ovf, and SHALL set packet_valid high for exactly the following cycle.
REQ-012 UPDATE SHALL last one cycle. cursor_x and cursor_y SHALL take their new values at its end, i.e. one cycle after packet_valid, and the FSM SHALL return to WAIT_B0.
REQ-013 A strobe arriving during UPDATE SHALL be processed under the WAIT_B0 rules, and the next state SHALL be chosen from it.
REQ-014 An idle counter SHALL run in WAIT_B1 and WAIT_B2 and SHALL clear on every strobe. When it reaches TIMEOUT_CYCLES, the FSM SHALL return to WAIT_B0, pulse sync_error and discard the partial packet.
REQ-015 A strobe and a timeout in the same cycle SHALL give priority to the strobe.
REQ-016 The X update SHALL be cursor_x = clamp(cursor_x + dx, 0, X_MAX), computed in 11-bit signed arithmetic.
REQ-017 The Y update SHALL be cursor_y = clamp(cursor_y - dy, 0, Y_MAX), computed in 11-bit signed arithmetic.
REQ-018 When x_ovf is set, cursor_x SHALL remain unchanged, and likewise for y_ovf and cursor_y. dx and dy SHALL still report the raw values.
REQ-019 dx, dy, buttons and both ovf outputs SHALL hold their values until the next packet.

Reset
REQ-020 On reset the block SHALL set:
- FSM to WAIT_B0
- ack_pending to 1
- idle counter to 0
- packet_valid and sync_error to 0
- buttons, dx, dy, x_ovf and y_ovf to 0
- cursor_x to X_MAX/2 (319)
- cursor_y to Y_MAX/2 (239)
REQ-021 Reset asserted mid-packet SHALL discard the partial packet, and SHALL generate no packet_valid and no sync_error.

Structure
REQ-022 Package mouse_pkg SHALL hold:
- FSM state encodings
- byte0 bit positions (button, sync, sign and overflow bits)
- the ACK constant 0xFA
- default X_MAX, Y_MAX and TIMEOUT_CYCLES
REQ-023 Sub-module mouse_axis_accum (add or subtract, overflow skip, clamp) SHALL be instantiated once per axis.

Verification
REQ-024 Reset, then bytes 0xFA, 0x08, 0x05, 0x03 SHALL give:
- one packet_valid, no sync_error
- dx=+5, dy=+3
- cursor_x 319->324, cursor_y 239->236
REQ-025 Bytes 0x38, 0xFB, 0xFE SHALL give:
- dx=9'h1FB (-5), dy=9'h1FE (-2)
- cursor_x 319->314, cursor_y 239->241
REQ-026 Packet 0x08, 0x7F, 0x00 sent three times from reset SHALL give cursor_x 446, then 573, then 639 (clamped).
REQ-027 Byte 0x00 in WAIT_B0 SHALL give one sync_error pulse and no packet_valid. A following 0x09, 0x00, 0x00 SHALL give buttons=3'b001.
REQ-028 Bytes 0x08, 0x10, then idle for TIMEOUT_CYCLES, SHALL give one sync_error pulse. A following 0x0A, 0x01, 0x01 SHALL then give buttons=3'b010, dx=+1, dy=+1.
REQ-029 Bytes 0x48, 0xFF, 0x00 SHALL give x_ovf=1, dx=+255 and cursor_x unchanged. Reset asserted after 0x08, 0x01 SHALL give no pulse, and the outputs SHALL return to their reset values.
